// File: rtl/nco_pkg.sv
// Shared definitions for the quadrature NCO: pipeline latency, quadrant encoding and the
// quarter-wave table generator used by nco_qlut at elaboration time.
package nco_pkg;

   localparam int unsigned NCO_LATENCY = 3;

   // Top two bits of a truncated phase select the quadrant of the full turn.
   typedef enum logic [1:0] {
      QuadI   = 2'd0,
      QuadII  = 2'd1,
      QuadIII = 2'd2,
      QuadIV  = 2'd3
   } quad_e;

   localparam real NcoPi = 3.14159265358979323846;

   // Quarter-wave entry k, sampled at the half-step point so mirrored reads are exact.
   function automatic int unsigned lut_entry(input int unsigned k,
                                             input int unsigned lut_aw,
                                             input int unsigned out_w);
      real amp;
      real ang;
      amp = real'((2 ** (out_w - 1)) - 1);
      ang = 2.0 * NcoPi * (real'(k) + 0.5) / real'(2 ** (lut_aw + 2));
      return int'($rtoi(amp * $sin(ang) + 0.5));
   endfunction

   // Sine half of the turn is negative in the lower two quadrants.
   function automatic logic quad_negate(input quad_e q);
      return (q == QuadIII) || (q == QuadIV);
   endfunction

   // Odd quadrants read the table backwards.
   function automatic logic quad_mirror(input quad_e q);
      return (q == QuadII) || (q == QuadIV);
   endfunction

endpackage

// File: rtl/nco_qlut.sv
// Dual-read quarter-wave sine ROM with registered outputs; one port serves the sine channel,
// the other the cosine channel. Magnitudes are unsigned, OUT_W-1 bits.
module nco_qlut
   import nco_pkg::*;
#(
   parameter int unsigned LUT_AW = 8,
   parameter int unsigned OUT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [LUT_AW-1:0] i_sin_addr,
   input  logic [LUT_AW-1:0] i_cos_addr,
   output logic [OUT_W-2:0]  o_sin_mag,
   output logic [OUT_W-2:0]  o_cos_mag
);

   localparam int unsigned Depth = 2 ** LUT_AW;

   logic [OUT_W-2:0] rom [Depth];
   logic [OUT_W-2:0] sin_mag_q;
   logic [OUT_W-2:0] cos_mag_q;

   for (genvar k = 0; k < Depth; k++) begin : g_rom
      assign rom[k] = (OUT_W - 1)'(lut_entry(k, LUT_AW, OUT_W));
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sin_mag_q <= '0;
         cos_mag_q <= '0;
      end else begin
         sin_mag_q <= rom[i_sin_addr];
         cos_mag_q <= rom[i_cos_addr];
      end
   end

   assign o_sin_mag = sin_mag_q;
   assign o_cos_mag = cos_mag_q;

endmodule

// File: rtl/nco_quad.sv
// Phase-accumulator NCO with quadrature sin/cos output, 3-stage pipeline (phase/offset,
// fold + LUT read, negate). Optional phase dither enabled by defining NCO_DITHER_EN.
module nco_quad
   import nco_pkg::*;
#(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned LUT_AW  = 8,
   parameter int unsigned OUT_W   = 16
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_ce,
   input  logic               i_fcw_wr,
   input  logic [PHASE_W-1:0] i_fcw,
   input  logic [PHASE_W-1:0] i_phase_ofs,
   input  logic               i_phase_clr,
   output logic               o_valid,
   output logic [OUT_W-1:0]   o_sin,
   output logic [OUT_W-1:0]   o_cos
);

   localparam int unsigned PhW   = LUT_AW + 2;
   localparam int unsigned DropW = PHASE_W - PhW;

   // Accumulator and frequency control word
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASE_W-1:0] fcw_q, fcw_d;

   always_comb begin
      phase_d = phase_q;
      if (i_phase_clr) begin
         phase_d = '0;
      end else if (i_ce) begin
         phase_d = phase_q + fcw_q;
      end
      fcw_d = i_fcw_wr ? i_fcw : fcw_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         phase_q <= '0;
         fcw_q   <= '0;
      end else begin
         phase_q <= phase_d;
         fcw_q   <= fcw_d;
      end
   end

   // Dither source
   logic [PHASE_W-1:0] dith;

`ifdef NCO_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
   always_comb begin
      lfsr_d = lfsr_q;
      if (i_ce) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   if (DropW >= 16) begin : g_dith_wide
      assign dith = PHASE_W'(lfsr_q) << (DropW - 16);
   end else begin : g_dith_narrow
      assign dith = PHASE_W'(lfsr_q >> (16 - DropW));
   end
`else
   assign dith = '0;
`endif

   // S1: offset the pre-update phase and truncate to the LUT phase domain
   logic [PHASE_W-1:0] p_full;
   logic [PhW-1:0]     sin_ph, cos_ph;
   logic [PhW-1:0]     s1_sin_ph_q, s1_cos_ph_q;
   logic               s1_valid_q;
   logic               unused_ph_lsb;

   assign p_full        = phase_q + i_phase_ofs + dith;
   assign sin_ph        = p_full[PHASE_W-1 -: PhW];
   assign cos_ph        = sin_ph + PhW'(2 ** LUT_AW);
   assign unused_ph_lsb = ^p_full[DropW-1:0];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_sin_ph_q <= '0;
         s1_cos_ph_q <= '0;
      end else begin
         s1_valid_q  <= i_ce;
         s1_sin_ph_q <= sin_ph;
         s1_cos_ph_q <= cos_ph;
      end
   end

   // S2: quadrant fold and registered LUT read
   quad_e             sin_quad, cos_quad;
   logic [LUT_AW-1:0] sin_a, cos_a;
   logic [LUT_AW-1:0] sin_addr, cos_addr;
   logic [OUT_W-2:0]  sin_mag, cos_mag;
   logic              s2_valid_q;
   logic              s2_sin_neg_q, s2_cos_neg_q;

   always_comb begin
      sin_quad = quad_e'(s1_sin_ph_q[PhW-1 -: 2]);
      cos_quad = quad_e'(s1_cos_ph_q[PhW-1 -: 2]);
      sin_a    = s1_sin_ph_q[LUT_AW-1:0];
      cos_a    = s1_cos_ph_q[LUT_AW-1:0];
      sin_addr = quad_mirror(sin_quad) ? ~sin_a : sin_a;
      cos_addr = quad_mirror(cos_quad) ? ~cos_a : cos_a;
   end

   nco_qlut #(
      .LUT_AW (LUT_AW),
      .OUT_W  (OUT_W)
   ) u_qlut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_sin_addr (sin_addr),
      .i_cos_addr (cos_addr),
      .o_sin_mag  (sin_mag),
      .o_cos_mag  (cos_mag)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s2_valid_q   <= 1'b0;
         s2_sin_neg_q <= 1'b0;
         s2_cos_neg_q <= 1'b0;
      end else begin
         s2_valid_q   <= s1_valid_q;
         s2_sin_neg_q <= quad_negate(sin_quad);
         s2_cos_neg_q <= quad_negate(cos_quad);
      end
   end

   // S3: apply sign; outputs only update on a valid sample
   logic [OUT_W-1:0] sin_ext, cos_ext;
   logic [OUT_W-1:0] sin_sgn, cos_sgn;
   logic [OUT_W-1:0] sin_q, cos_q;
   logic             valid_q;

   always_comb begin
      sin_ext = {1'b0, sin_mag};
      cos_ext = {1'b0, cos_mag};
      sin_sgn = s2_sin_neg_q ? (~sin_ext + 1'b1) : sin_ext;
      cos_sgn = s2_cos_neg_q ? (~cos_ext + 1'b1) : cos_ext;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid_q <= 1'b0;
         sin_q   <= '0;
         cos_q   <= '0;
      end else begin
         valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            sin_q <= sin_sgn;
            cos_q <= cos_sgn;
         end
      end
   end

   assign o_valid = valid_q;
   assign o_sin   = sin_q;
   assign o_cos   = cos_q;

endmodule

// File: tb/tb_nco_quad.sv
// Directed self-checking bench for nco_quad (PHASE_W=32, LUT_AW=8, OUT_W=16, no dither).
module tb_nco_quad;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic        fcw_wr;
   logic [31:0] fcw;
   logic [31:0] ofs;
   logic        clr;
   logic        valid;
   logic [15:0] sin_o;
   logic [15:0] cos_o;

   always #5 clk = ~clk;

   nco_quad #(
      .PHASE_W (32),
      .LUT_AW  (8),
      .OUT_W   (16)
   ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_ce        (ce),
      .i_fcw_wr    (fcw_wr),
      .i_fcw       (fcw),
      .i_phase_ofs (ofs),
      .i_phase_clr (clr),
      .o_valid     (valid),
      .o_sin       (sin_o),
      .o_cos       (cos_o)
   );

   int n_chk = 0;
   int n_err = 0;

   // Stimulus vector i is driven in cycle i; expectation j is seen three cycles later.
   logic        v_ce  [16];
   logic        v_wr  [16];
   logic        v_clr [16];
   logic [31:0] v_fcw [16];
   logic [31:0] v_ofs [16];
   logic        e_val [16];
   int          e_sin [16];
   int          e_cos [16];

   int sin4 [4] = '{101, 32767, -101, -32767};
   int cos4 [4] = '{32767, -101, -32767, 101};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   task automatic drive_idle();
      ce     = 1'b0;
      fcw_wr = 1'b0;
      fcw    = '0;
      ofs    = '0;
      clr    = 1'b0;
   endtask

   task automatic clear_vec();
      for (int i = 0; i < 16; i++) begin
         v_ce[i]  = 1'b0;
         v_wr[i]  = 1'b0;
         v_clr[i] = 1'b0;
         v_fcw[i] = '0;
         v_ofs[i] = '0;
         e_val[i] = 1'b0;
         e_sin[i] = 0;
         e_cos[i] = 0;
      end
   endtask

   task automatic set_vec(input int i, input logic c, input logic w, input logic [31:0] f,
                          input logic cl, input logic [31:0] o);
      v_ce[i]  = c;
      v_wr[i]  = w;
      v_fcw[i] = f;
      v_clr[i] = cl;
      v_ofs[i] = o;
   endtask

   task automatic set_exp(input int j, input logic v, input int s, input int c);
      e_val[j] = v;
      e_sin[j] = s;
      e_cos[j] = c;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input string name, input int n);
      for (int c = 0; c < n + 3; c++) begin
         @(negedge clk);
         if (c >= 3) begin
            check_val($sformatf("%s[%0d].valid", name, c - 3), 32'(valid), 32'(e_val[c - 3]));
            check_val($sformatf("%s[%0d].sin", name, c - 3), sx(sin_o), e_sin[c - 3]);
            check_val($sformatf("%s[%0d].cos", name, c - 3), sx(cos_o), e_cos[c - 3]);
         end
         if (c < n) begin
            ce     = v_ce[c];
            fcw_wr = v_wr[c];
            fcw    = v_fcw[c];
            clr    = v_clr[c];
            ofs    = v_ofs[c];
         end else begin
            drive_idle();
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();
      @(negedge clk);
      check_val("rst.valid", 32'(valid), 32'd0);
      check_val("rst.sin", sx(sin_o), 32'd0);
      check_val("rst.cos", sx(cos_o), 32'd0);
      rst_n = 1'b1;

      // Quarter-turn steps: four-sample repeating pattern, cos leading sin
      clear_vec();
      set_vec(0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, '0);
      for (int i = 1; i <= 8; i++) begin
         set_vec(i, 1'b1, 1'b0, '0, 1'b0, '0);
         set_exp(i, 1'b1, sin4[(i - 1) % 4], cos4[(i - 1) % 4]);
      end
      run_vec("quarter", 9);

      // Reset asserted mid-run clears outputs without waiting for a clock edge
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ce = 1'b1;
      end
      @(negedge clk);
      check_val("midrun.valid_pre", 32'(valid), 32'd1);
      #2;
      rst_n = 1'b0;
      ce    = 1'b0;
      #1;
      check_val("midrun.valid", 32'(valid), 32'd0);
      check_val("midrun.sin", sx(sin_o), 32'd0);
      check_val("midrun.cos", sx(cos_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_val("idle.valid", 32'(valid), 32'd0);
      check_val("idle.sin", sx(sin_o), 32'd0);

      // All-ones FCW: phase 0, FFFFFFFF, FFFFFFFE (just below zero -> sample 1023)
      do_reset();
      clear_vec();
      set_vec(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, '0);
      for (int i = 1; i <= 3; i++) set_vec(i, 1'b1, 1'b0, '0, 1'b0, '0);
      set_exp(1, 1'b1, 101, 32767);
      set_exp(2, 1'b1, -101, 32767);
      set_exp(3, 1'b1, -101, 32767);
      run_vec("wrap", 4);

      // FCW write coinciding with ce: that step still uses the old word
      do_reset();
      clear_vec();
      set_vec(0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, '0);
      set_vec(1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, '0);
      set_vec(2, 1'b1, 1'b0, '0, 1'b0, '0);
      set_vec(3, 1'b1, 1'b0, '0, 1'b0, '0);
      set_exp(1, 1'b1, 101, 32767);
      set_exp(2, 1'b1, 32767, -101);
      set_exp(3, 1'b1, -32767, 101);
      run_vec("fcwwr", 4);

      // Phase clear with ce: in-flight samples intact, next sample from phase 0
      do_reset();
      clear_vec();
      set_vec(0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, '0);
      set_vec(1, 1'b1, 1'b0, '0, 1'b0, '0);
      set_vec(2, 1'b1, 1'b0, '0, 1'b0, '0);
      set_vec(3, 1'b1, 1'b0, '0, 1'b1, '0);
      set_vec(4, 1'b1, 1'b0, '0, 1'b0, '0);
      set_exp(1, 1'b1, 101, 32767);
      set_exp(2, 1'b1, 32767, -101);
      set_exp(3, 1'b1, -101, -32767);
      set_exp(4, 1'b1, 101, 32767);
      run_vec("clr", 5);

      // ce 1,0,1: valid follows three cycles later and outputs hold across the gap
      do_reset();
      clear_vec();
      set_vec(0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, '0);
      set_vec(1, 1'b1, 1'b0, '0, 1'b0, '0);
      set_vec(2, 1'b0, 1'b0, '0, 1'b0, '0);
      set_vec(3, 1'b1, 1'b0, '0, 1'b0, '0);
      set_exp(1, 1'b1, 101, 32767);
      set_exp(2, 1'b0, 101, 32767);
      set_exp(3, 1'b1, 32767, -101);
      run_vec("cegap", 4);

      // Phase offset applied on top of a zero accumulator
      do_reset();
      clear_vec();
      set_vec(0, 1'b1, 1'b0, '0, 1'b0, 32'h8000_0000);
      set_vec(1, 1'b1, 1'b0, '0, 1'b0, 32'h4000_0000);
      set_exp(0, 1'b1, -101, -32767);
      set_exp(1, 1'b1, 32767, -101);
      run_vec("ofs", 2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
